// File: rtl/hopfield_pkg.sv
// Shared types and sizing helpers for the Hopfield recall engine.
// Holds the FSM encoding, adder-tree width and weight saturation limits.
package hopfield_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_LEARN,
    S_RECALL,
    S_FINISH
  } fsm_e;

  // Row sum never overflows: N terms of magnitude <= 2^(WW-1).
  function automatic int sum_w(input int n, input int ww);
    return ww + $clog2(n) + 1;
  endfunction

  function automatic int w_max(input int ww);
    return (1 << (ww - 1)) - 1;
  endfunction

  function automatic int w_min(input int ww);
    return -(1 << (ww - 1));
  endfunction

endpackage

// File: rtl/hopfield_row_mac.sv
// Signed weighted sum of one weight row against the neuron state.
// A set state bit adds the weight, a clear bit subtracts it.
module hopfield_row_mac
  import hopfield_pkg::*;
#(
  parameter int N  = 25,
  parameter int WW = 4,
  parameter int SW = sum_w(N, WW)
) (
  input  logic [N*WW-1:0]      i_row,
  input  logic [N-1:0]         i_state,
  output logic signed [SW-1:0] o_sum
);

  logic signed [SW-1:0] w_t;

  always_comb begin
    o_sum = '0;
    w_t   = '0;
    for (int m = 0; m < N; m++) begin
      w_t   = SW'($signed(i_row[m*WW +: WW]));
      o_sum = i_state[m] ? o_sum + w_t : o_sum - w_t;
    end
  end

endmodule

// File: rtl/hopfield_engine.sv
// Hopfield associative memory: Hebbian learning into saturating weights
// and asynchronous one-neuron-per-cycle recall until a fixed point.
module hopfield_engine
  import hopfield_pkg::*;
#(
  parameter int N         = 25,
  parameter int WW        = 4,
  parameter int MAX_SWEEP = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         learn_valid,
  output logic         learn_ready,
  input  logic [N-1:0] learn_pattern,
  input  logic         recall_start,
  input  logic [N-1:0] init_state,
  output logic [N-1:0] state,
  output logic         busy,
  output logic         done,
  output logic         converged,
  output logic [3:0]   sweeps
);

  localparam int IW   = $clog2(N);
  localparam int SW   = sum_w(N, WW);
  localparam int WMAX = w_max(WW);
  localparam int WMIN = w_min(WW);
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  fsm_e r_fsm, w_fsm_nxt;

  logic [N*WW-1:0] r_w [N];
  logic [N-1:0]    r_state;
  logic [N-1:0]    r_pat;
  logic [IW-1:0]   r_idx;
  logic [3:0]      r_sweeps;
  logic            r_conv;
  logic            r_chg;
  logic            r_init;

  logic [N*WW-1:0]      w_row;
  logic [N*WW-1:0]      w_learn_row;
  logic [N*WW-1:0]      w_wdata;
  logic signed [SW-1:0] w_sum;
  logic                 w_last;
  logic                 w_new;
  logic                 w_chg;
  logic                 w_any;
  logic                 w_stop;
  logic                 w_we;
  int                   w_t;

  assign w_row  = r_w[r_idx];
  assign w_last = r_idx == LAST;

  hopfield_row_mac #(
    .N  (N),
    .WW (WW)
  ) u_mac (
    .i_row   (w_row),
    .i_state (r_state),
    .o_sum   (w_sum)
  );

  // A zero sum is a tie: the neuron keeps its value.
  assign w_new  = (w_sum == '0) ? r_state[r_idx] : !w_sum[SW-1];
  assign w_chg  = w_new != r_state[r_idx];
  assign w_any  = r_chg | w_chg;
  assign w_stop = !w_any || (r_sweeps + 4'd1 == 4'(MAX_SWEEP));

  always_comb begin
    w_learn_row = '0;
    w_t         = 0;
    for (int m = 0; m < N; m++) begin
      w_t = int'($signed(w_row[m*WW +: WW]))
          + ((r_pat[r_idx] == r_pat[m]) ? 1 : -1);
      if (w_t > WMAX) w_t = WMAX;
      else if (w_t < WMIN) w_t = WMIN;
      if (r_idx == IW'(m)) w_t = 0;
      w_learn_row[m*WW +: WW] = WW'(w_t);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_fsm <= S_IDLE;
    else      r_fsm <= w_fsm_nxt;
  end

  always_comb begin
    w_fsm_nxt = r_fsm;
    case (r_fsm)
      S_IDLE: begin
        if (r_init || clear)   w_fsm_nxt = S_CLEAR;
        else if (learn_valid)  w_fsm_nxt = S_LEARN;
        else if (recall_start) w_fsm_nxt = S_RECALL;
      end
      S_CLEAR:  if (w_last) w_fsm_nxt = S_IDLE;
      S_LEARN:  if (w_last) w_fsm_nxt = S_IDLE;
      S_RECALL: if (w_last && w_stop) w_fsm_nxt = S_FINISH;
      S_FINISH: w_fsm_nxt = S_IDLE;
      default:  w_fsm_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy        = r_fsm != S_IDLE;
    done        = r_fsm == S_FINISH;
    learn_ready = (r_fsm == S_IDLE) && !clear && !r_init;
    w_we        = (r_fsm == S_CLEAR) || (r_fsm == S_LEARN);
    w_wdata     = (r_fsm == S_LEARN) ? w_learn_row : '0;
  end

  // Weights are wiped by the CLEAR pass that follows reset release.
  always_ff @(posedge clk) begin
    if (w_we) r_w[r_idx] <= w_wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= '0;
      r_pat    <= '0;
      r_idx    <= '0;
      r_sweeps <= '0;
      r_conv   <= 1'b0;
      r_chg    <= 1'b0;
      r_init   <= 1'b1;
    end else begin
      case (r_fsm)
        S_IDLE: begin
          r_idx <= '0;
          if (r_init) begin
            r_init <= 1'b0;
          end else if (clear) begin
            r_init <= 1'b0;
          end else if (learn_valid) begin
            r_pat <= learn_pattern;
          end else if (recall_start) begin
            r_state  <= init_state;
            r_sweeps <= '0;
            r_conv   <= 1'b0;
            r_chg    <= 1'b0;
          end
        end
        S_CLEAR, S_LEARN: begin
          r_idx <= w_last ? '0 : r_idx + 1'b1;
        end
        S_RECALL: begin
          r_state[r_idx] <= w_new;
          if (w_last) begin
            r_idx    <= '0;
            r_sweeps <= r_sweeps + 4'd1;
            r_chg    <= 1'b0;
            r_conv   <= !w_any;
          end else begin
            r_idx <= r_idx + 1'b1;
            r_chg <= w_any;
          end
        end
        default: r_idx <= '0;
      endcase
    end
  end

  assign state     = r_state;
  assign converged = r_conv;
  assign sweeps    = r_sweeps;

endmodule

// File: tb/tb_hopfield_engine.sv
// Directed bench for hopfield_engine with a weight/recall reference
// model feeding a scoreboard of expected recall results.
module tb_hopfield_engine;

  localparam int N  = 25;
  localparam int WW = 4;
  localparam int MS = 8;

  localparam logic [N-1:0] PD = 25'b0111010010100101001001111;
  localparam logic [N-1:0] PC = 25'b0011101001010000100011111;
  localparam logic [N-1:0] PJ = 25'b1111000001000010000111110;
  localparam logic [N-1:0] PM = 25'b1000110001101011101110001;

  logic clk = 1'b0;
  logic rst, clear, learn_valid, recall_start;
  logic [N-1:0] learn_pattern, init_state;
  logic learn_ready, busy, done, converged;
  logic [N-1:0] state;
  logic [3:0] sweeps;

  logic clear2, lv2, rs2;
  logic [N-1:0] lp2, is2;
  logic lr2, b2, d2, c2;
  logic [N-1:0] st2;
  logic [3:0] sw2;

  int n_total = 0;
  int n_bad   = 0;
  int mw [N][N];

  typedef struct {
    logic [N-1:0] st;
    logic         cv;
    int           sw;
    int           lat;
    int           flips;
  } exp_t;
  exp_t q[$];

  always #5 clk = ~clk;

  hopfield_engine #(.N(N), .WW(WW), .MAX_SWEEP(MS)) dut (
    .clk(clk), .rst(rst), .clear(clear),
    .learn_valid(learn_valid), .learn_ready(learn_ready),
    .learn_pattern(learn_pattern), .recall_start(recall_start),
    .init_state(init_state), .state(state), .busy(busy),
    .done(done), .converged(converged), .sweeps(sweeps)
  );

  hopfield_engine #(.N(N), .WW(2), .MAX_SWEEP(MS)) dut2 (
    .clk(clk), .rst(rst), .clear(clear2),
    .learn_valid(lv2), .learn_ready(lr2),
    .learn_pattern(lp2), .recall_start(rs2),
    .init_state(is2), .state(st2), .busy(b2),
    .done(d2), .converged(c2), .sweeps(sw2)
  );

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    n_total++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic m_clear();
    for (int k = 0; k < N; k++)
      for (int m = 0; m < N; m++) mw[k][m] = 0;
  endtask

  task automatic m_learn(input logic [N-1:0] p);
    int t;
    for (int k = 0; k < N; k++)
      for (int m = 0; m < N; m++)
        if (m != k) begin
          t = mw[k][m] + ((p[k] == p[m]) ? 1 : -1);
          if (t > 7) t = 7;
          if (t < -8) t = -8;
          mw[k][m] = t;
        end
  endtask

  task automatic m_recall(input logic [N-1:0] init, output exp_t e);
    logic [N-1:0] s;
    logic chg, nb;
    int sum;
    s = init;
    e.sw = 0;
    e.flips = 0;
    e.cv = 1'b0;
    forever begin
      chg = 1'b0;
      for (int k = 0; k < N; k++) begin
        sum = 0;
        for (int m = 0; m < N; m++)
          sum += s[m] ? mw[k][m] : -mw[k][m];
        nb = (sum > 0) ? 1'b1 : (sum < 0) ? 1'b0 : s[k];
        if (nb != s[k]) begin
          chg = 1'b1;
          e.flips++;
        end
        s[k] = nb;
      end
      e.sw++;
      if (!chg) begin
        e.cv = 1'b1;
        break;
      end
      if (e.sw == MS) break;
    end
    e.st  = s;
    e.lat = e.sw * N + 1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!learn_ready && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 300) chk("ready_timeout", learn_ready, 1);
  endtask

  task automatic learn(input logic [N-1:0] p);
    wait_ready();
    learn_valid = 1'b1;
    learn_pattern = p;
    @(posedge clk); #1;
    learn_valid = 1'b0;
    m_learn(p);
    wait_ready();
  endtask

  task automatic check_weights(input string tag);
    logic [N*WW-1:0] er;
    for (int k = 0; k < N; k++) begin
      er = '0;
      for (int m = 0; m < N; m++) er[m*WW +: WW] = 4'(mw[k][m]);
      chk($sformatf("%s_row%0d", tag, k), dut.r_w[k], er);
    end
  endtask

  task automatic recall(input string tag, input logic [N-1:0] init);
    exp_t e;
    int cyc, tog;
    logic [N-1:0] prev;
    m_recall(init, e);
    q.push_back(e);
    wait_ready();
    recall_start = 1'b1;
    init_state = init;
    @(posedge clk); #1;
    recall_start = 1'b0;
    cyc = 0;
    tog = 0;
    prev = state;
    while (!done && cyc < 400) begin
      @(posedge clk); #1;
      cyc++;
      if (state !== prev) tog++;
      prev = state;
    end
    e = q.pop_front();
    chk({tag, "_done"}, done, 1);
    chk({tag, "_state"}, state, e.st);
    chk({tag, "_conv"}, converged, e.cv);
    chk({tag, "_sweeps"}, sweeps, e.sw);
    chk({tag, "_latency"}, cyc + 1, e.lat);
    chk({tag, "_toggles"}, tog, e.flips);
    @(posedge clk); #1;
    chk({tag, "_pulse"}, done, 0);
    chk({tag, "_hold"}, state, e.st);
  endtask

  initial begin
    int bc, dc, n;
    logic seen;
    logic [N-1:0] p;
    logic [N*2-1:0] er2;

    rst = 1'b0;
    clear = 1'b0; learn_valid = 1'b0; recall_start = 1'b0;
    learn_pattern = '0; init_state = '0;
    clear2 = 1'b0; lv2 = 1'b0; rs2 = 1'b0; lp2 = '0; is2 = '0;
    m_clear();

    repeat (3) @(posedge clk);
    #1;
    chk("rst_state", state, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_conv", converged, 0);
    chk("rst_sweeps", sweeps, 0);

    // Recall requested right at reset release must be swallowed by CLEAR.
    rst = 1'b1;
    recall_start = 1'b1;
    init_state = '1;
    bc = 0; dc = 0; seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (busy) begin
        bc++;
        seen = 1'b1;
      end
      if (seen && !busy) recall_start = 1'b0;
      if (done) dc++;
    end
    recall_start = 1'b0;
    chk("init_clear_len", bc, N);
    chk("init_no_done", dc, 0);
    chk("init_state", state, 0);
    chk("init_idle", busy, 0);

    // Narrow-weight instance: repeated learning saturates at +1 / -2.
    p = PD;
    for (int r = 0; r < 3; r++) begin
      n = 0;
      while (!lr2 && n < 300) begin
        @(posedge clk); #1;
        n++;
      end
      lv2 = 1'b1;
      lp2 = p;
      @(posedge clk); #1;
      lv2 = 1'b0;
    end
    n = 0;
    while (!lr2 && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    chk("ww2_ready", lr2, 1);
    for (int k = 0; k < N; k++) begin
      er2 = '0;
      for (int m = 0; m < N; m++)
        if (m != k) er2[m*2 +: 2] = (p[k] == p[m]) ? 2'b01 : 2'b10;
      chk($sformatf("ww2_row%0d", k), dut2.r_w[k], er2);
    end

    learn(PD);
    p = PD;
    p[7] = ~p[7];
    recall("d_flip7", p);
    chk("d_flip7_isD", state, PD);
    chk("d_flip7_sw2", sweeps, 2);
    chk("d_flip7_cv1", converged, 1);

    learn(PC);
    learn(PJ);
    learn(PM);
    check_weights("w4");
    recall("exact_D", PD);
    recall("exact_C", PC);
    recall("exact_J", PJ);
    recall("exact_M", PM);
    for (int r = 0; r < 2; r++) begin
      p = N'($urandom);
      recall($sformatf("rand%0d", r), p);
    end

    // Clear outranks a simultaneous learn request.
    wait_ready();
    clear = 1'b1;
    learn_valid = 1'b1;
    learn_pattern = PJ;
    #1;
    chk("clr_not_ready", learn_ready, 0);
    @(posedge clk); #1;
    clear = 1'b0;
    learn_valid = 1'b0;
    m_clear();
    wait_ready();
    check_weights("clr");
    recall("ties", 25'h155AAAA);
    chk("ties_state", state, 25'h155AAAA);
    chk("ties_sw1", sweeps, 1);

    learn(PD);
    wait_ready();
    p = PD;
    p[3] = ~p[3];
    recall_start = 1'b1;
    init_state = p;
    @(posedge clk); #1;
    recall_start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("abort_state", state, 0);
    chk("abort_busy", busy, 0);
    chk("abort_sweeps", sweeps, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    m_clear();
    dc = 0;
    for (int i = 0; i < 3 * N; i++) begin
      @(posedge clk); #1;
      if (done) dc++;
    end
    chk("abort_no_done", dc, 0);
    chk("abort_state_kept", state, 0);
    wait_ready();
    check_weights("abort");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
